mem_dma: RTL and testbench
==========================

# mem_dma

Memory-bus initiator that fills or copies a block of 16-bit words through the Hack memory map (RAM 0x0000–0x3FFF, screen 0x4000–0x5FFF, keyboard 0x6000). It drives the same `address`/`in`/`load` port set that the CPU drives into `memory`. It honours the one-cycle read latency and the screen's `busy` stall, so a clear-screen or scroll runs without CPU instruction loops. It sits beside the CPU, and a top-level mux grants it the memory port while `active` is high.

## Interface
- No parameters.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- mode  input  1  0 = fill, 1 = copy; sampled with `start`.
- src  input  16  copy source base address; sampled with `start`.
- dst  input  16  destination base address; sampled with `start`.
- len  input  16  word count, 0–65535; sampled with `start`.
- fill_value  input  16  word written in fill mode; sampled with `start`.
- mem_address  output  16  address to memory.
- mem_in  output  16  write data to memory.
- mem_load  output  1  write strobe to memory.
- mem_out  input  16  read data from memory, valid the cycle after a read address is presented.
- mem_busy  input  1  memory stall; an access presented while high is not accepted.
- active  output  1  high from the cycle after an accepted `start` until the cycle after the done pulse.
- done  output  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE.
  - RD: present the source address with `mem_load`=0.
  - CAP: capture the read data.
  - WR: present the destination address and data with `mem_load`=1.
  - FIN.
- IDLE:
  - On `start`=1, latch `src`, `dst`, `len`, `mode` and `fill_value` into internal registers sa, da, rem, md and fv.
  - If `len`=0, go to FIN.
  - Otherwise go to WR for fill, or RD for copy.
  - `start` is ignored in every other state.
- RD:
  - `mem_address`=sa, `mem_load`=0.
  - If `mem_busy`=0, go to CAP. Otherwise stay in RD and re-present the address.
- CAP:
  - Hold register ← `mem_out`.
  - `mem_address` still equals sa; `mem_load`=0.
  - Go to WR.
- WR:
  - `mem_address`=da, `mem_load`=1.
  - `mem_in`=fv in fill mode, or the hold register in copy mode.
  - If `mem_busy`=1, hold all outputs and stay in WR.
  - Otherwise the write is accepted: da←da+1, sa←sa+1, rem←rem−1.
  - If the new rem is 0, go to FIN. Otherwise go to WR for fill, or RD for copy.
- FIN:
  - `done`=1 for exactly one cycle, `mem_load`=0.
  - Go to IDLE.
- Address arithmetic is 16-bit modulo 2^16: 0xFFFF+1 wraps to 0x0000.
- Copies always run ascending. For overlapping ranges with dst>src, the source data is overwritten before it is read; this is defined behaviour, not an error.
- `mem_load` is 1 only in WR. In IDLE, `mem_address` and `mem_in` hold their last values.
- Reset (any state, including mid-transfer):
  - Next state is IDLE.
  - `mem_load`=0, `active`=0, `done`=0, `mem_address`=0x0000, `mem_in`=0x0000; internal registers cleared.
  - No partial write completes after the reset edge.

## Timing
- Fill, no stalls: `start` at cycle T; words written at T+1 … T+len; `done` at T+len+1; `active` falls at T+len+2.
- Copy, no stalls: 3 cycles per word (RD, CAP, WR).
  - First read address at T+1; first write at T+3.
  - `done` at T+3·len+1.
- Each cycle with `mem_busy`=1 in RD or WR adds exactly one cycle. CAP ignores `mem_busy`.
- `len`=0: `done` at T+1; no cycle has `mem_load`=1.
- A `start` held high through the done cycle starts a new transfer in the first IDLE cycle after FIN, using the fresh `src`/`dst`/`len` values.

## Test plan
- **Fill:**
  - Stimulus: mode=0, dst=0x4000, len=4, fill_value=0xFFFF, `mem_busy`=0.
  - Required: writes to 0x4000–0x4003 on four consecutive cycles, each `mem_in`=0xFFFF; `done` exactly 5 cycles after `start`.
- **Copy with latency:**
  - Stimulus: RAM[0x0010..0x0012]=0x1111/0x2222/0x3333; copy src=0x0010, dst=0x0100, len=3.
  - Required: RAM[0x0100..0x0102] matches the source; each write occurs 2 cycles after its read address; `done` at T+10.
- **Busy stall:**
  - Stimulus: fill dst=0x4000, len=2, with `mem_busy` forced high for 3 cycles during the first WR.
  - Required: address 0x4000 and `mem_load`=1 held for 4 cycles; exactly one write per address; `done` at T+6.
- **Zero length and wrap:**
  - Stimulus 1: len=0. Required: `done` at T+1, no write.
  - Stimulus 2: fill dst=0xFFFF, len=2. Required: writes to 0xFFFF, then 0x0000.
- **Reset mid-transfer:**
  - Stimulus: assert `reset` during the 2nd WR of an 8-word fill.
  - Required: `mem_load`=0, `active`=0 and `mem_address`=0 the next cycle; later words never written; a subsequent `start` runs normally.
- **Start ignored while active:**
  - Stimulus: pulse `start` with different parameters mid-copy.
  - Required: the original transfer completes unchanged; no second `done`.

Source files
------------

// File: rtl/mem_dma_if.sv
// ============================================================================
// Module      : mem_dma_if
// Description : Hack memory-port bundle shared by the DMA initiator and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_dma_if;
    logic [15:0] mem_address;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_out;
    logic        mem_busy;

    modport master (
        output mem_address,
        output mem_in,
        output mem_load,
        input  mem_out,
        input  mem_busy
    );

    modport slave (
        input  mem_address,
        input  mem_in,
        input  mem_load,
        output mem_out,
        output mem_busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_dma.sv
// ============================================================================
// Module      : mem_dma
// Description : Block fill / ascending copy engine on the Hack memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_dma (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    input  wire logic        mode,
    input  wire logic [15:0] src,
    input  wire logic [15:0] dst,
    input  wire logic [15:0] len,
    input  wire logic [15:0] fill_value,
    output logic             active,
    output logic             done,
    mem_dma_if.master        bus
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RD   = 3'd1;
    localparam logic [2:0] c_CAP  = 3'd2;
    localparam logic [2:0] c_WR   = 3'd3;
    localparam logic [2:0] c_FIN  = 3'd4;

    logic [2:0]  r_state, w_state_nxt;
    logic [15:0] r_sa, w_sa_nxt;
    logic [15:0] r_da, w_da_nxt;
    logic [15:0] r_rem, w_rem_nxt;
    logic [15:0] r_fv, w_fv_nxt;
    logic [15:0] r_hold, w_hold_nxt;
    logic        r_md, w_md_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [15:0] r_wdata, w_wdata_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_sa_nxt    = r_sa;
        w_da_nxt    = r_da;
        w_rem_nxt   = r_rem;
        w_fv_nxt    = r_fv;
        w_hold_nxt  = r_hold;
        w_md_nxt    = r_md;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_sa_nxt = src;
                    w_da_nxt = dst;
                    w_rem_nxt = len;
                    w_md_nxt = mode;
                    w_fv_nxt = fill_value;
                    if (len == 16'd0)
                        w_state_nxt = c_FIN;
                    else
                        w_state_nxt = mode ? c_RD : c_WR;
                end
            end
            c_RD: begin
                if (!bus.mem_busy)
                    w_state_nxt = c_CAP;
            end
            c_CAP: begin
                w_hold_nxt  = bus.mem_out;
                w_state_nxt = c_WR;
            end
            c_WR: begin
                if (!bus.mem_busy) begin
                    w_sa_nxt  = r_sa + 16'd1;
                    w_da_nxt  = r_da + 16'd1;
                    w_rem_nxt = r_rem - 16'd1;
                    if (r_rem == 16'd1)
                        w_state_nxt = c_FIN;
                    else
                        w_state_nxt = r_md ? c_RD : c_WR;
                end
            end
            c_FIN: w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Bus address/data are registered from the next state so they line up
    // with the state they belong to and hold their value through IDLE/FIN.
    always_comb begin
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        case (w_state_nxt)
            c_RD, c_CAP: w_addr_nxt = w_sa_nxt;
            c_WR: begin
                w_addr_nxt  = w_da_nxt;
                w_wdata_nxt = w_md_nxt ? w_hold_nxt : w_fv_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_sa    <= 16'd0;
            r_da    <= 16'd0;
            r_rem   <= 16'd0;
            r_fv    <= 16'd0;
            r_hold  <= 16'd0;
            r_md    <= 1'b0;
            r_addr  <= 16'd0;
            r_wdata <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_sa    <= w_sa_nxt;
            r_da    <= w_da_nxt;
            r_rem   <= w_rem_nxt;
            r_fv    <= w_fv_nxt;
            r_hold  <= w_hold_nxt;
            r_md    <= w_md_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign active          = (r_state != c_IDLE);
    assign done            = (r_state == c_FIN);
    assign bus.mem_load    = (r_state == c_WR);
    assign bus.mem_address = r_addr;
    assign bus.mem_in      = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_dma.sv
// ============================================================================
// Module      : tb_mem_dma
// Description : Scoreboard bench for mem_dma against a one-cycle-latency RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_dma;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [15:0] src, dst, len, fill_value;
    logic        active, done;

    mem_dma_if bus ();

    mem_dma dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .fill_value (fill_value),
        .active     (active),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] ram [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr, pre_data;

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (bus.mem_load && !bus.mem_busy)
            ram[bus.mem_address] <= bus.mem_in;
        bus.mem_out <= ram[bus.mem_address];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    wr_t exp_wr_q[$];
    int  exp_done_q[$];
    wr_t e_wr;
    int  e_done;

    // Scoreboard: every accepted write and every done pulse must be expected.
    always @(negedge clk) begin
        if (!reset && bus.mem_load && !bus.mem_busy) begin
            check("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
            if (exp_wr_q.size() != 0) begin
                e_wr = exp_wr_q.pop_front();
                check("wr_addr", 32'(bus.mem_address), 32'(e_wr.addr));
                check("wr_data", 32'(bus.mem_in), 32'(e_wr.data));
                check("wr_cycle", cyc, e_wr.cyc);
            end
        end
        if (!reset && done) begin
            check("done_expected", 32'(exp_done_q.size() != 0), 32'd1);
            if (exp_done_q.size() != 0) begin
                e_done = exp_done_q.pop_front();
                check("done_cycle", cyc, e_done);
            end
        end
    end

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic launch(input logic m, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic [15:0] fv, output int t);
        t = cyc;
        mode = m; src = s; dst = d; len = l; fill_value = fv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_fill(input int t, input logic [15:0] d, input int l, input logic [15:0] fv);
        for (int i = 0; i < l; i++)
            exp_wr_q.push_back('{addr: d + 16'(i), data: fv, cyc: t + 1 + i});
        exp_done_q.push_back(t + l + 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_done_q.size() != 0 || active) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("xfer_timeout", exp_done_q.size(), 0);
    endtask

    logic [15:0] cpy [3] = '{16'h1111, 16'h2222, 16'h3333};

    initial begin
        int t;
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        src = '0; dst = '0; len = '0; fill_value = '0;
        bus.mem_busy = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_load", bus.mem_load, 1'b0);
        check("rst_active", active, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr", bus.mem_address, 16'h0000);
        check("rst_in", bus.mem_in, 16'h0000);
        reset = 1'b0;
        @(posedge clk); #1;

        // Fill four screen words.
        launch(1'b0, 16'h0000, 16'h4000, 16'd4, 16'hFFFF, t);
        push_fill(t, 16'h4000, 4, 16'hFFFF);
        wait_idle();

        // Copy three words with read latency.
        for (int i = 0; i < 3; i++) poke(16'h0010 + 16'(i), cpy[i]);
        launch(1'b1, 16'h0010, 16'h0100, 16'd3, 16'h0000, t);
        for (int i = 0; i < 3; i++)
            exp_wr_q.push_back('{addr: 16'h0100 + 16'(i), data: cpy[i], cyc: t + 3 + 3 * i});
        exp_done_q.push_back(t + 10);
        check("copy_rd_addr", bus.mem_address, 16'h0010);
        check("copy_rd_load", bus.mem_load, 1'b0);
        wait_idle();
        for (int i = 0; i < 3; i++) check("copy_ram", ram[16'h0100 + 16'(i)], cpy[i]);

        // Busy stall on the first write.
        launch(1'b0, 16'h0000, 16'h4000, 16'd2, 16'h5A5A, t);
        exp_wr_q.push_back('{addr: 16'h4000, data: 16'h5A5A, cyc: t + 4});
        exp_wr_q.push_back('{addr: 16'h4001, data: 16'h5A5A, cyc: t + 5});
        exp_done_q.push_back(t + 6);
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_busy = 1'b0;
            check("stall_addr", bus.mem_address, 16'h4000);
            check("stall_load", bus.mem_load, 1'b1);
            @(posedge clk); #1;
        end
        wait_idle();

        // Zero length.
        launch(1'b0, 16'h0000, 16'h2000, 16'd0, 16'h1234, t);
        exp_done_q.push_back(t + 1);
        wait_idle();

        // Address wrap.
        launch(1'b0, 16'h0000, 16'hFFFF, 16'd2, 16'hA5A5, t);
        exp_wr_q.push_back('{addr: 16'hFFFF, data: 16'hA5A5, cyc: t + 1});
        exp_wr_q.push_back('{addr: 16'h0000, data: 16'hA5A5, cyc: t + 2});
        exp_done_q.push_back(t + 3);
        wait_idle();

        // Reset during the second write of an 8-word fill.
        for (int i = 0; i < 8; i++) poke(16'h0300 + 16'(i), 16'h0000);
        launch(1'b0, 16'h0000, 16'h0300, 16'd8, 16'h7777, t);
        exp_wr_q.push_back('{addr: 16'h0300, data: 16'h7777, cyc: t + 1});
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_load", bus.mem_load, 1'b0);
        check("mrst_active", active, 1'b0);
        check("mrst_addr", bus.mem_address, 16'h0000);
        check("mrst_in", bus.mem_in, 16'h0000);
        repeat (10) @(posedge clk);
        #1;
        check("mrst_word0", ram[16'h0300], 16'h7777);
        for (int i = 2; i < 8; i++) check("mrst_unwritten", ram[16'h0300 + 16'(i)], 16'h0000);
        launch(1'b0, 16'h0000, 16'h0400, 16'd2, 16'hBEEF, t);
        push_fill(t, 16'h0400, 2, 16'hBEEF);
        wait_idle();

        // Start pulse during an active copy is ignored.
        launch(1'b1, 16'h0010, 16'h0200, 16'd3, 16'h0000, t);
        for (int i = 0; i < 3; i++)
            exp_wr_q.push_back('{addr: 16'h0200 + 16'(i), data: cpy[i], cyc: t + 3 + 3 * i});
        exp_done_q.push_back(t + 10);
        repeat (3) @(posedge clk);
        #1;
        mode = 1'b0; dst = 16'h5000; len = 16'd5; fill_value = 16'hDEAD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check("ign_ram", ram[16'h0200 + 16'(i)], cpy[i]);

        check("wr_queue_empty", exp_wr_q.size(), 0);
        check("done_queue_empty", exp_done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
